// File: rtl/l2_msg_pkg.sv
// Shared L2 message definitions: message-type codes, field widths and the
// packed message struct carried on the msg3 response channel.
package l2_msg_pkg;

  localparam int TYPE_W = 8;
  localparam int SRC_W  = 6;
  localparam int TAG_W  = 26;
  localparam int DATA_W = 64;

  localparam logic [TYPE_W-1:0] LOAD_MEM      = 8'd19;
  localparam logic [TYPE_W-1:0] STORE_MEM     = 8'd20;
  localparam logic [TYPE_W-1:0] LOAD_MEM_ACK  = 8'd24;
  localparam logic [TYPE_W-1:0] STORE_MEM_ACK = 8'd25;

  typedef struct packed {
    logic [TYPE_W-1:0] msg_type;
    logic [SRC_W-1:0]  source;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } l2_msg_t;

endpackage

// File: rtl/l2_resp_fifo.sv
// Generic DEPTH-entry FIFO of l2_msg_t. The head entry is read directly from
// storage; push is ignored when full and pop is ignored when empty.
module l2_resp_fifo
  import l2_msg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  l2_msg_t                push_data,
  input  logic                   pop,
  output l2_msg_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  l2_msg_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/l2_mem_resp_queue.sv
// msg3 ingress: classifies memory responses against outstanding msg2 requests,
// buffers legal acks and presents them to the L2 pipeline.
module l2_mem_resp_queue
  import l2_msg_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [TYPE_W-1:0]              mem_type,
  input  logic [SRC_W-1:0]               mem_source,
  input  logic [TAG_W-1:0]               mem_tag,
  input  logic [DATA_W-1:0]              mem_data,
  output logic                           msg3_valid,
  input  logic                           msg3_ready,
  output logic [TYPE_W-1:0]              msg3_type,
  output logic [SRC_W-1:0]               msg3_source,
  output logic [TAG_W-1:0]               msg3_tag,
  output logic [DATA_W-1:0]              msg3_data,
  input  logic                           msg2_valid,
  input  logic                           msg2_ready,
  input  logic [TYPE_W-1:0]              msg2_type,
  output logic [$clog2(MAX_OUT+1)-1:0]   ld_outstanding,
  output logic [$clog2(MAX_OUT+1)-1:0]   st_outstanding,
  output logic                           err_bad_type,
  output logic                           err_unexpected,
  output logic                           err_overflow
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  l2_msg_t                 push_msg;
  l2_msg_t                 head;
  l2_msg_t                 msg_out;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;

  logic accept, pop, push;
  logic is_ld_ack, is_st_ack;
  logic ld_inc, st_inc, ld_dec, st_dec;
  logic ld_at_max, st_at_max;

  // Ready depends only on registered occupancy, never on msg3_ready.
  assign mem_ready  = !rst && !fifo_full;
  assign accept     = mem_valid && mem_ready;
  assign msg3_valid = (fifo_count != '0);
  assign pop        = msg3_valid && msg3_ready;

  assign is_ld_ack = (mem_type == LOAD_MEM_ACK);
  assign is_st_ack = (mem_type == STORE_MEM_ACK);

  // Zero checks use the pre-cycle counts, so a same-cycle issue cannot legalise an ack.
  assign ld_dec = accept && is_ld_ack && (ld_outstanding != '0);
  assign st_dec = accept && is_st_ack && (st_outstanding != '0);
  assign push   = ld_dec || st_dec;

  assign ld_inc    = msg2_valid && msg2_ready && (msg2_type == LOAD_MEM);
  assign st_inc    = msg2_valid && msg2_ready && (msg2_type == STORE_MEM);
  assign ld_at_max = (ld_outstanding == CNT_MAX);
  assign st_at_max = (st_outstanding == CNT_MAX);

  assign push_msg = '{msg_type: mem_type, source: mem_source, tag: mem_tag, data: mem_data};

  l2_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_msg),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_outstanding <= '0;
      st_outstanding <= '0;
      err_bad_type   <= 1'b0;
      err_unexpected <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      if (ld_inc && !ld_dec && !ld_at_max) ld_outstanding <= ld_outstanding + 1'b1;
      else if (ld_dec && !ld_inc)          ld_outstanding <= ld_outstanding - 1'b1;

      if (st_inc && !st_dec && !st_at_max) st_outstanding <= st_outstanding + 1'b1;
      else if (st_dec && !st_inc)          st_outstanding <= st_outstanding - 1'b1;

      if (accept && !is_ld_ack && !is_st_ack) err_bad_type <= 1'b1;
      if (accept && ((is_ld_ack && ld_outstanding == '0) ||
                     (is_st_ack && st_outstanding == '0)))
        err_unexpected <= 1'b1;
      if ((ld_inc && !ld_dec && ld_at_max) || (st_inc && !st_dec && st_at_max))
        err_overflow <= 1'b1;
    end
  end

  assign msg_out     = fifo_empty ? '0 : head;
  assign msg3_type   = msg_out.msg_type;
  assign msg3_source = msg_out.source;
  assign msg3_tag    = msg_out.tag;
  assign msg3_data   = msg_out.data;

endmodule

// File: doc/l2_mem_resp_queue.md
# l2_mem_resp_queue

Ingress stage on the L2 memory-response channel (msg3). It accepts responses from the memory controller, drops illegal or unexpected ones, buffers legal acks in a small FIFO and presents them to the L2 pipeline on the msg3 valid/ready interface. It also snoops the L2 request channel (msg2) to track outstanding LOAD_MEM/STORE_MEM requests, so every forwarded ack is matched to a prior request.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- MAX_OUT, 15: maximum outstanding requests per kind (load, store).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_valid  in  1  memory response valid.
- mem_ready  out  1  queue accepts the response this cycle.
- mem_type  in  8  response message type.
- mem_source  in  6  response source id.
- mem_tag  in  26  line tag.
- mem_data  in  64  line data.
- msg3_valid  out  1  response presented to L2.
- msg3_ready  in  1  L2 consumes the response.
- msg3_type / msg3_source / msg3_tag / msg3_data  out  8/6/26/64  head-entry payload.
- msg2_valid, msg2_ready  in  1 each  L2 request handshake (snooped only).
- msg2_type  in  8  L2 request type (snooped only).
- ld_outstanding, st_outstanding  out  $clog2(MAX_OUT+1)  outstanding request counts.
- err_bad_type, err_unexpected, err_overflow  out  1 each  sticky error flags.

## Operation
- Types: LOAD_MEM 8'd19, STORE_MEM 8'd20, LOAD_MEM_ACK 8'd24, STORE_MEM_ACK 8'd25 (8'h19).
- Accept = mem_valid && mem_ready. On accept:
  - Type not in {LOAD_MEM_ACK, STORE_MEM_ACK}: drop the response; set err_bad_type.
  - Matching outstanding counter is 0: drop the response; set err_unexpected.
  - Otherwise: enqueue {type, source, tag, data} and decrement the matching counter.
- Issue = msg2_valid && msg2_ready && msg2_type is LOAD_MEM or STORE_MEM.
  - On issue, increment the matching counter.
  - If that counter is already at MAX_OUT, hold it and set err_overflow.
- Increment and decrement of the same counter in the same cycle: counter unchanged, no error.
  - The zero check uses the pre-cycle value, so an issue and an ack in the same cycle with count 0 still flags err_unexpected and drops the ack.
- Pop = msg3_valid && msg3_ready; advances the head pointer.
- Error flags are sticky and clear only on rst.

## Timing
- Reset values: msg3_valid 0, msg3_* payload 0, mem_ready 0 while rst is high, counters 0, pointers 0, error flags 0.
- mem_ready = !rst && (count != DEPTH). It is a function of registered count only; there is no combinational path from msg3_ready.
  - When full, mem_ready stays 0 even if a pop occurs in the same cycle.
- Latency: an ack accepted at edge N gives msg3_valid=1 in the cycle after edge N, with the payload equal to the accepted fields.
- msg3_valid = (count != 0). The payload comes straight from the head entry and is forced to 0 when msg3_valid is 0.
- Once msg3_valid is 1, the payload holds stable until the pop.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- Full throughput: one accept and one pop per cycle in steady state.
- rst mid-operation: all buffered entries and outstanding counts are discarded. Responses still in flight after rst must be flagged err_unexpected.

## Structure
- Shared package l2_msg_pkg holds:
  - the message-type localparams (LOAD_MEM, STORE_MEM, LOAD_MEM_ACK, STORE_MEM_ACK);
  - the field widths: TYPE_W 8, SRC_W 6, TAG_W 26, DATA_W 64;
  - a packed struct l2_msg_t {type, source, tag, data}.
- Sub-module l2_resp_fifo: generic DEPTH × l2_msg_t FIFO with push/pop/full/empty/count.
- The top level holds the classification logic, the outstanding counters and the error flags.

## Test plan
- Issue STORE_MEM, then ack type 8'h19, tag 26'h0ABCDEF, data 64'hDEADBEEF_00000001 → msg3_valid=1 one cycle after accept with identical fields; st_outstanding 1→0; no error flags.
- Issue 4 LOAD_MEM, hold msg3_ready=0, send 4 LOAD_MEM_ACK → mem_ready=0 after the 4th accept. Then assert msg3_ready=1 → FIFO drains in order, 4 consecutive cycles.
- STORE_MEM_ACK with st_outstanding=0 → dropped, msg3_valid stays 0, err_unexpected=1 and stays 1.
- mem_type 8'h07 with counts nonzero → dropped, err_bad_type=1, counters unchanged.
- 15 STORE_MEM issues, then a 16th → st_outstanding holds at 15, err_overflow=1. A STORE_MEM issue and a STORE_MEM_ACK accept in the same cycle at count 3 → count stays 3.
- rst asserted with 2 entries queued → next cycle msg3_valid=0, counters 0, all error flags 0, mem_ready=1 after rst deasserts.
